// File: rtl/aes_block_loader.sv
// rtl/aes_block_loader.sv - word-to-block loader feeding the AES wrapper (optional AES_LOADER_TIMEOUT_EN)
module aes_block_loader #(
  parameter int WORD_WIDTH     = 32,
  parameter int DATA_WIDTH     = 128,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_word,
  input  logic                  in_is_key,
  input  logic                  in_flag,
  output logic [DATA_WIDTH-1:0] plan_text_128,
  output logic [DATA_WIDTH-1:0] cipher_key_128,
  output logic                  flag,
  output logic                  valid_in,
  output logic                  key_loaded,
  output logic                  err_no_key,
  output logic                  err_timeout
);

  localparam int NWORDS = DATA_WIDTH / WORD_WIDTH;
  localparam int WCNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NWORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_EMIT    = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WCNT_W-1:0]     r_wcnt;
  logic [WCNT_W-1:0]     w_wcnt_nxt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_assembled;
  logic [DATA_WIDTH-1:0] r_plain;
  logic [DATA_WIDTH-1:0] r_key;
  logic                  r_is_key;
  logic                  r_flag;
  logic                  r_valid;
  logic                  r_key_loaded;
  logic                  r_err_no_key;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_frame_is_key;
  logic                  w_timeout;

  // The source may only hand over a word outside reset and outside the emit cycle.
  assign in_ready       = rst_n && (r_state != S_EMIT);
  assign w_accept       = in_valid && in_ready;
  assign w_last         = w_accept && (r_wcnt == LAST_WORD);
  // Frame type comes from word 0; later words reuse the latched copy.
  assign w_frame_is_key = (r_wcnt == '0) ? in_is_key : r_is_key;

  assign plan_text_128  = r_plain;
  assign cipher_key_128 = r_key;
  assign flag           = r_flag;
  assign valid_in       = r_valid;
  assign key_loaded     = r_key_loaded;
  assign err_no_key     = r_err_no_key;

`ifdef AES_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_stall;
  logic          r_err_timeout;

  // Idle-cycle counter inside a partial frame; any accepted word restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall <= '0;
    end else if ((r_state != S_COLLECT) || w_accept || w_timeout) begin
      r_stall <= '0;
    end else begin
      r_stall <= r_stall + 1'b1;
    end
  end

  // A word arriving on the expiry edge wins over the abort.
  assign w_timeout = (r_state == S_COLLECT) && !w_accept &&
                     (r_stall == TW'(TIMEOUT_CYCLES - 1));

  // Abort pulse lands in the cycle after the expiry edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_timeout <= 1'b0;
    end else begin
      r_err_timeout <= w_timeout;
    end
  end

  assign err_timeout = r_err_timeout;
`else
  assign w_timeout   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Current shift contents with the incoming word dropped into its slot (word 0 is the MSB slot).
  always_comb begin
    w_assembled = r_shift;
    w_assembled[DATA_WIDTH - 1 - WORD_WIDTH * int'(r_wcnt) -: WORD_WIDTH] = in_word;
  end

  // State and word-counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  // Next-state: count words, branch to EMIT only for a data frame with a key present.
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    case (r_state)
      S_IDLE, S_COLLECT: begin
        if (w_accept) begin
          if (r_wcnt == LAST_WORD) begin
            w_wcnt_nxt  = '0;
            w_state_nxt = (!w_frame_is_key && r_key_loaded) ? S_EMIT : S_IDLE;
          end else begin
            w_wcnt_nxt  = r_wcnt + 1'b1;
            w_state_nxt = S_COLLECT;
          end
        end else if (w_timeout) begin
          w_wcnt_nxt  = '0;
          w_state_nxt = S_IDLE;
        end
      end
      S_EMIT: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_wcnt_nxt  = '0;
      end
    endcase
  end

  // Datapath: shift in words, commit key or block on the last word, raise pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift      <= '0;
      r_plain      <= '0;
      r_key        <= '0;
      r_is_key     <= 1'b0;
      r_flag       <= 1'b0;
      r_valid      <= 1'b0;
      r_key_loaded <= 1'b0;
      r_err_no_key <= 1'b0;
    end else begin
      r_valid      <= 1'b0;
      r_err_no_key <= 1'b0;
      if (w_accept) begin
        r_shift <= w_assembled;
        if (r_wcnt == '0) begin
          r_is_key <= in_is_key;
        end
      end
      if (w_last) begin
        if (w_frame_is_key) begin
          r_key        <= w_assembled;
          r_key_loaded <= 1'b1;
        end else if (r_key_loaded) begin
          r_plain <= w_assembled;
          r_flag  <= in_flag;
          r_valid <= 1'b1;
        end else begin
          r_err_no_key <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_block_loader.sv
// tb/tb_aes_block_loader.sv - scoreboard bench for aes_block_loader
module tb_aes_block_loader;

  localparam logic [1:0] K_BLOCK   = 2'd0;
  localparam logic [1:0] K_NOKEY   = 2'd1;
  localparam logic [1:0] K_TIMEOUT = 2'd2;

  typedef struct packed {
    logic [1:0]   kind;
    logic [127:0] pt;
    logic         fl;
    logic [127:0] key;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_word = '0;
  logic         in_is_key = 1'b0;
  logic         in_flag = 1'b0;
  logic [127:0] plan_text_128;
  logic [127:0] cipher_key_128;
  logic         flag;
  logic         valid_in;
  logic         key_loaded;
  logic         err_no_key;
  logic         err_timeout;

  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc     = 0;
  int   rdy_low = 0;
  exp_t q[$];
  int   vcyc[$];
  exp_t mon_e;

  logic [127:0] m_key = '0;
  logic [127:0] m_pt  = '0;
  logic         m_key_loaded = 1'b0;

  aes_block_loader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_word        (in_word),
    .in_is_key      (in_is_key),
    .in_flag        (in_flag),
    .plan_text_128  (plan_text_128),
    .cipher_key_128 (cipher_key_128),
    .flag           (flag),
    .valid_in       (valid_in),
    .key_loaded     (key_loaded),
    .err_no_key     (err_no_key),
    .err_timeout    (err_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard whenever the DUT raises an output event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!in_ready) rdy_low++;
      if (valid_in) vcyc.push_back(cyc);
      if (valid_in || err_no_key || err_timeout) begin
        if (q.size() == 0) begin
          check("unexpected_event", {125'd0, valid_in, err_no_key, err_timeout}, 128'd0);
        end else begin
          mon_e = q.pop_front();
          if (mon_e.kind == K_BLOCK) begin
            check("block_valid_in", 128'(valid_in), 128'd1);
            check("block_plan_text", plan_text_128, mon_e.pt);
            check("block_flag", 128'(flag), 128'(mon_e.fl));
            check("block_key", cipher_key_128, mon_e.key);
            check("block_in_ready_low", 128'(in_ready), 128'd0);
          end else if (mon_e.kind == K_NOKEY) begin
            check("nokey_pulse", 128'(err_no_key), 128'd1);
            check("nokey_no_valid", 128'(valid_in), 128'd0);
            check("nokey_plan_text", plan_text_128, mon_e.pt);
          end else begin
            check("timeout_pulse", 128'(err_timeout), 128'd1);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_word(input logic [31:0] w, input logic k, input logic f);
    int t;
    in_valid  = 1'b1;
    in_word   = w;
    in_is_key = k;
    in_flag   = f;
    t = 0;
    while (!in_ready && t < 20) begin
      tick();
      t++;
    end
    if (t >= 20) check("in_ready_wait", 128'(in_ready), 128'd1);
    tick();
  endtask

  // Words 1..3 carry the opposite type bit and words 0..2 the opposite flag; both must be ignored.
  task automatic send_words(input logic [127:0] blk, input logic is_key, input logic fl,
                            input int first, input int last);
    for (int k = first; k <= last; k++) begin
      send_word(blk[127 - 32 * k -: 32], (k == 0) ? is_key : ~is_key, (k == 3) ? fl : ~fl);
    end
  endtask

  task automatic send_frame(input logic [127:0] blk, input logic is_key, input logic fl);
    exp_t e;
    if (is_key) begin
      send_words(blk, 1'b1, fl, 0, 3);
      m_key = blk;
      m_key_loaded = 1'b1;
    end else begin
      if (m_key_loaded) begin
        e = '{kind: K_BLOCK, pt: blk, fl: fl, key: m_key};
        m_pt = blk;
      end else begin
        e = '{kind: K_NOKEY, pt: m_pt, fl: 1'b0, key: m_key};
      end
      q.push_back(e);
      send_words(blk, 1'b0, fl, 0, 3);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_plan_text"}, plan_text_128, 128'd0);
    check({tag, "_key"}, cipher_key_128, 128'd0);
    check({tag, "_flag"}, 128'(flag), 128'd0);
    check({tag, "_valid_in"}, 128'(valid_in), 128'd0);
    check({tag, "_key_loaded"}, 128'(key_loaded), 128'd0);
    check({tag, "_err_no_key"}, 128'(err_no_key), 128'd0);
    check({tag, "_err_timeout"}, 128'(err_timeout), 128'd0);
    check({tag, "_in_ready_low"}, 128'(in_ready), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int r0;
    exp_t e;
    logic [127:0] b2b [3];
    b2b[0] = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    b2b[1] = 128'hdead_beef_cafe_f00d_0bad_c0de_1234_5678;
    b2b[2] = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();
    check("ready_after_release", 128'(in_ready), 128'd1);

    send_frame(128'hffee_ddcc_bbaa_9988_7766_5544_3322_1100, 1'b0, 1'b1);
    idle(3);

    send_frame(128'h0001_0203_0405_0607_0809_0a0b_0c0d_0e0f, 1'b1, 1'b1);
    check("key_loaded", 128'(key_loaded), 128'd1);
    check("cipher_key", cipher_key_128, 128'h0001_0203_0405_0607_0809_0a0b_0c0d_0e0f);
    idle(2);

    send_frame(128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff, 1'b0, 1'b1);
    idle(3);

    n0 = vcyc.size();
    r0 = rdy_low;
    send_frame(b2b[0], 1'b0, 1'b0);
    send_frame(b2b[1], 1'b0, 1'b1);
    send_frame(b2b[2], 1'b0, 1'b0);
    idle(3);
    check("b2b_pulses", 128'(vcyc.size() - n0), 128'd3);
    if (vcyc.size() - n0 == 3) begin
      check("b2b_spacing_1", 128'(vcyc[n0 + 1] - vcyc[n0]), 128'd5);
      check("b2b_spacing_2", 128'(vcyc[n0 + 2] - vcyc[n0 + 1]), 128'd5);
    end
    check("b2b_ready_drops", 128'(rdy_low - r0), 128'd3);

`ifdef AES_LOADER_TIMEOUT_EN
    e = '{kind: K_TIMEOUT, pt: m_pt, fl: 1'b0, key: m_key};
    q.push_back(e);
    send_words(128'h9999_9999_8888_8888_7777_7777_6666_6666, 1'b0, 1'b0, 0, 1);
    idle(260);
    send_frame(128'haabb_ccdd_0102_0304_a5a5_5a5a_0f0f_f0f0, 1'b0, 1'b1);
`else
    e = '{kind: K_BLOCK, pt: 128'haabb_ccdd_0102_0304_a5a5_5a5a_0f0f_f0f0, fl: 1'b1, key: m_key};
    q.push_back(e);
    m_pt = 128'haabb_ccdd_0102_0304_a5a5_5a5a_0f0f_f0f0;
    send_words(128'haabb_ccdd_0102_0304_a5a5_5a5a_0f0f_f0f0, 1'b0, 1'b1, 0, 1);
    idle(300);
    send_words(128'haabb_ccdd_0102_0304_a5a5_5a5a_0f0f_f0f0, 1'b0, 1'b1, 2, 3);
`endif
    idle(4);

    send_words(128'h1357_9bdf_2468_ace0_1122_3344_5566_7788, 1'b0, 1'b1, 0, 2);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    m_key_loaded = 1'b0;
    m_key = '0;
    m_pt = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    idle(8);
    check("midreset_ready", 128'(in_ready), 128'd1);
    check("midreset_key_loaded", 128'(key_loaded), 128'd0);

    check("scoreboard_empty", 128'(q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/aes_block_loader.md
# aes_block_loader

Upstream input stage for the AES wrapper. It accepts a stream of 32-bit words over a valid/ready handshake, assembles 4-word frames into a 128-bit round key or a 128-bit plaintext block, and presents them on the `plan_text_128`, `cipher_key_128`, `flag` and `valid_in` signals the wrapper samples. The key is held until it is reloaded. Each data frame produces one `valid_in` pulse.

## Interface
- `WORD_WIDTH`, 32, input word width; must divide `DATA_WIDTH`.
- `DATA_WIDTH`, 128, assembled block and key width.
- `TIMEOUT_CYCLES`, 255, stall limit inside a partial frame; used only with `AES_LOADER_TIMEOUT_EN`.
- `clk` in 1: single clock; all logic rising-edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: input word valid.
- `in_ready` out 1: loader can accept a word.
- `in_word` in WORD_WIDTH: input word; the first word of a frame is the most significant.
- `in_is_key` in 1: frame type, sampled on word 0 only; 1 = key frame, 0 = data frame.
- `in_flag` in 1: mode flag, sampled on word 3 of a data frame only.
- `plan_text_128` out DATA_WIDTH: last assembled plaintext.
- `cipher_key_128` out DATA_WIDTH: current key.
- `flag` out 1: flag of the last emitted block.
- `valid_in` out 1: one-cycle pulse; block is valid.
- `key_loaded` out 1: a full key frame has been accepted since reset.
- `err_no_key` out 1: one-cycle pulse; a data frame completed with no key loaded.
- `err_timeout` out 1: one-cycle pulse; a partial frame was aborted. Tied 0 when the feature is compiled out.

## Operation
- A word is accepted on a rising edge with `in_valid && in_ready`.
- A 2-bit word counter `wcnt` counts 0..3 and wraps to 0 after word 3.
- States:
  - IDLE: `wcnt == 0`, `in_ready = 1`.
  - COLLECT: `wcnt` is 1..3, `in_ready = 1`.
  - EMIT: lasts one cycle, `in_ready = 0`.
- IDLE → COLLECT on accepting word 0. Word 0 latches the frame type from `in_is_key`.
- Word k (0..3) is written to shift-register bits [127-32k : 96-32k].
- Word 3 of a key frame:
  - `cipher_key_128` takes the assembled value on the same edge.
  - `key_loaded` goes to 1.
  - Next state is IDLE. There is no EMIT and no `valid_in` pulse.
- Word 3 of a data frame with `key_loaded = 1`:
  - `plan_text_128` takes the assembled value and `flag` takes `in_flag`.
  - Next state is EMIT; `valid_in = 1` for exactly that cycle.
- Word 3 of a data frame with `key_loaded = 0`:
  - The block is discarded; `plan_text_128` and `flag` are unchanged.
  - `err_no_key` pulses in the next cycle. Next state is IDLE.
- EMIT → IDLE unconditionally. A word offered during EMIT is not accepted and must be held by the source.
- `plan_text_128`, `cipher_key_128` and `flag` keep their values between loads.
- A key frame that follows a data frame never alters an already-emitted block. The wrapper registers both buses on the `valid_in` cycle.
- `in_is_key` on words 1..3 and `in_flag` on words 0..2 (and on any key-frame word) are ignored.

## Timing
- Reset (asynchronous assert, synchronous-to-clk release) puts the block in IDLE with `wcnt = 0`.
- Reset values:
  - All data outputs are 0.
  - `valid_in`, `key_loaded`, `err_no_key` and `err_timeout` are 0.
  - `in_ready` is 0 while `rst_n` is low and 1 from the first cycle after release.
- Reset in mid-frame discards the partial frame and the key.
- Latency, with data word 3 accepted on edge N:
  - `valid_in` is high during cycle N+1 (from edge N to edge N+1).
  - `in_ready` is low during that same cycle.
  - The next word can be accepted at edge N+2.
- Throughput is one data block per 5 cycles at full input rate. A key frame takes 4 cycles.
- The wrapper adds 2 cycles, so its `valid_out` rises 3 cycles after edge N.
- Error pulses are registered and occupy the cycle after the offending edge.

## Configuration
- `AES_LOADER_TIMEOUT_EN` defined:
  - A stall counter runs in COLLECT. It is reset on each accepted word.
  - When it reaches `TIMEOUT_CYCLES` with no word accepted, the partial frame is discarded, `wcnt` returns to 0, the state goes to IDLE, and `err_timeout` pulses for 1 cycle.
  - If a word arrives on the same edge as expiry, the word is accepted and no timeout occurs.
- `AES_LOADER_TIMEOUT_EN` undefined: there is no counter, a partial frame waits indefinitely, and `err_timeout` is tied 0.

## Test plan
- Reset → all outputs 0; `in_ready = 1` the cycle after release.
- Key frame 00010203, 04050607, 08090a0b, 0c0d0e0f, then data frame 00112233, 44556677, 8899aabb, ccddeeff with `in_flag = 1` on the last word → `cipher_key_128 = 000102…0f`; one `valid_in` pulse with `plan_text_128 = 00112233…ccddeeff` and `flag = 1`; wrapper output 69c4e0d86a7b0430d8cdb78070b4c55a.
- Data frame with no key loaded → `err_no_key` pulses once, `valid_in` stays 0, and `plan_text_128` stays 0.
- Back-to-back data frames with `in_valid` held high → `in_ready` drops for exactly 1 cycle per frame, `valid_in` pulses every 5 cycles, and no word is lost or duplicated.
- 2 words, then `in_valid = 0` for 255 cycles (macro defined) → `err_timeout` pulses, and the next 4 words form a clean frame. With the macro undefined, the frame completes on the 3rd and 4th words after any gap.
- `rst_n` asserted after word 2 of a data frame → IDLE, `key_loaded = 0`, and no `valid_in`.
